load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 262 ++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Accepts one load or store at a time from the core and turns it into a
// single word-aligned transaction on a simple req/ack memory bus. The unit
// handles sub-word addressing:
//   - stores: the data is replicated across byte lanes and a byte mask is produced.
//   - loads: the addressed lane is extracted from the returned word, then sign- or zero-extended.
// Misaligned or illegal-size requests never reach the bus. A bus that does not
// acknowledge within TIMEOUT_CYCLES cycles causes the transfer to be abandoned,
// and a bus error is reported.
//
// Parameters
//   TIMEOUT_CYCLES  max BUS cycles waited for bus_ack_in (1..65535)
//
// Ports
//   clk_in            single clock, rising edge
//   reset_n_in        asynchronous active-low reset
//   req_valid_in      core presents a request
//   mem_wr_req_in     1 = store, 0 = load
//   load_size_in      00 byte, 01 half, 10 word, 11 illegal
//   load_unsigned_in  1 = zero-extend loads, 0 = sign-extend
//   addr_in           byte address
//   store_data_in     right-justified store data
//   req_ready_out     unit can accept a request this cycle (IDLE only)
//   bus_req_out       bus request, high for the whole BUS phase
//   bus_we_out        bus write enable
//   bus_addr_out      word-aligned bus address
//   bus_wdata_out     lane-replicated write data
//   bus_wmask_out     byte write mask (0000 for loads)
//   bus_ack_in        bus acknowledge
//   bus_rdata_in      full read word, valid with ack
//   load_data_out     last completed load result (held)
//   load_valid_out    1-cycle pulse: load completed
//   store_done_out    1-cycle pulse: store completed
//   misaligned_out    1-cycle pulse: request rejected as misaligned/illegal
//   bus_err_out       1-cycle pulse: bus timed out
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        req_valid_in,
    input  logic        mem_wr_req_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        req_ready_out,
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_wdata_out,
    output logic [3:0]  bus_wmask_out,
    input  logic        bus_ack_in,
    input  logic [31:0] bus_rdata_in,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        store_done_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Outcome of the current request; selects which pulse fires in DONE.
    localparam logic [1:0] RES_LOAD     = 2'd0;
    localparam logic [1:0] RES_STORE    = 2'd1;
    localparam logic [1:0] RES_MISALIGN = 2'd2;
    localparam logic [1:0] RES_BUSERR   = 2'd3;

    // The counter value seen in the last BUS cycle that may still be acked.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wmask_reg;
    logic [15:0] wait_cnt_reg;
    logic [1:0]  result_reg;
    logic [31:0] load_data_reg;

    logic        accept;
    logic        req_misaligned;
    logic [31:0] wdata_next;
    logic [3:0]  wmask_next;
    logic        in_bus;
    logic        in_done;
    logic        wait_expired;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign accept = req_valid_in && (state_reg == ST_IDLE);

    always_comb begin
        req_misaligned = 1'b0;
        case (load_size_in)
            SIZE_BYTE: req_misaligned = 1'b0;
            SIZE_HALF: req_misaligned = addr_in[0];
            SIZE_WORD: req_misaligned = (addr_in[1:0] != 2'b00);
            default:   req_misaligned = 1'b1;
        endcase
    end

    // Lane replication means the bus slave can take its bytes from the lanes
    // the mask enables without any shifting of its own.
    always_comb begin
        wdata_next = store_data_in;
        wmask_next = 4'b0000;
        case (load_size_in)
            SIZE_BYTE: begin
                wdata_next = {4{store_data_in[7:0]}};
                wmask_next = 4'b0001 << addr_in[1:0];
            end
            SIZE_HALF: begin
                wdata_next = {2{store_data_in[15:0]}};
                wmask_next = 4'b0011 << addr_in[1:0];
            end
            default: begin
                wdata_next = store_data_in;
                wmask_next = 4'b1111;
            end
        endcase
        if (!mem_wr_req_in) begin
            wmask_next = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Load lane extraction from the returned word
    // ------------------------------------------------------------------
    logic [7:0]  rdata_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_extended;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata_byte[gi] = bus_rdata_in[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rdata_byte[addr_reg[1:0]];
    // Aligned halves only ever sit at lane 0 or lane 2.
    assign half_sel = addr_reg[1] ? {rdata_byte[3], rdata_byte[2]}
                                  : {rdata_byte[1], rdata_byte[0]};

    always_comb begin
        load_extended = bus_rdata_in;
        case (size_reg)
            SIZE_BYTE: load_extended = {{24{~unsigned_reg & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_extended = {{16{~unsigned_reg & half_sel[15]}}, half_sel};
            default:   load_extended = bus_rdata_in;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign wait_expired = (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = req_misaligned ? ST_DONE : ST_BUS;
                end
            end
            // Ack wins over an expiring counter in the same cycle.
            ST_BUS: begin
                if (bus_ack_in || wait_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_reg     <= ST_IDLE;
            we_reg        <= 1'b0;
            size_reg      <= 2'b00;
            unsigned_reg  <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wmask_reg     <= '0;
            wait_cnt_reg  <= '0;
            result_reg    <= RES_LOAD;
            load_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        we_reg       <= mem_wr_req_in;
                        size_reg     <= load_size_in;
                        unsigned_reg <= load_unsigned_in;
                        addr_reg     <= addr_in;
                        wdata_reg    <= wdata_next;
                        wmask_reg    <= wmask_next;
                        wait_cnt_reg <= '0;
                        if (req_misaligned) begin
                            result_reg <= RES_MISALIGN;
                        end else if (mem_wr_req_in) begin
                            result_reg <= RES_STORE;
                        end else begin
                            result_reg <= RES_LOAD;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_ack_in) begin
                        if (!we_reg) begin
                            load_data_reg <= load_extended;
                        end
                    end else if (wait_expired) begin
                        result_reg <= RES_BUSERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state so reset acts on them at once
    // ------------------------------------------------------------------
    assign in_bus  = (state_reg == ST_BUS);
    assign in_done = (state_reg == ST_DONE);

    assign req_ready_out  = (state_reg == ST_IDLE);
    assign bus_req_out    = in_bus;
    assign bus_we_out     = in_bus & we_reg;
    assign bus_addr_out   = in_bus ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign bus_wdata_out  = in_bus ? wdata_reg : 32'd0;
    assign bus_wmask_out  = in_bus ? wmask_reg : 4'd0;

    assign load_data_out  = load_data_reg;
    // A single result code guarantees the completion pulses are exclusive.
    assign load_valid_out = in_done && (result_reg == RES_LOAD);
    assign store_done_out = in_done && (result_reg == RES_STORE);
    assign misaligned_out = in_done && (result_reg == RES_MISALIGN);
    assign bus_err_out    = in_done && (result_reg == RES_BUSERR);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic        req_valid_in;
    logic        mem_wr_req_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic        req_ready_out;
    logic        bus_req_out;
    logic        bus_we_out;
    logic [31:0] bus_addr_out;
    logic [31:0] bus_wdata_out;
    logic [3:0]  bus_wmask_out;
    logic        bus_ack_in;
    logic [31:0] bus_rdata_in;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        store_done_out;
    logic        misaligned_out;
    logic        bus_err_out;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_load_data = 32'd0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .req_valid_in(req_valid_in), .mem_wr_req_in(mem_wr_req_in),
        .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
        .addr_in(addr_in), .store_data_in(store_data_in),
        .req_ready_out(req_ready_out), .bus_req_out(bus_req_out),
        .bus_we_out(bus_we_out), .bus_addr_out(bus_addr_out),
        .bus_wdata_out(bus_wdata_out), .bus_wmask_out(bus_wmask_out),
        .bus_ack_in(bus_ack_in), .bus_rdata_in(bus_rdata_in),
        .load_data_out(load_data_out), .load_valid_out(load_valid_out),
        .store_done_out(store_done_out), .misaligned_out(misaligned_out),
        .bus_err_out(bus_err_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One complete transaction, checked cycle by cycle against expectations
    // derived from the address/size rules with plain arithmetic.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int ack_delay);
        int          lane;
        int          nbytes;
        logic        exp_mis;
        logic        ok;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
        logic [63:0] lmask;
        logic [63:0] raw;
        logic        exp_lv;
        logic        exp_sd;
        logic        exp_be;

        lane    = int'(addr % 4);
        exp_mis = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
        nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_mask = we ? 4'(((1 << nbytes) - 1) << lane) : 4'd0;
        if (nbytes == 1)      exp_wdata = (sdata & 32'hFF) * 32'h0101_0101;
        else if (nbytes == 2) exp_wdata = (sdata & 32'hFFFF) * 32'h0001_0001;
        else                  exp_wdata = sdata;
        lmask = (64'd1 << (8 * nbytes)) - 64'd1;
        raw   = ({32'd0, rdata} >> (8 * lane)) & lmask;
        if (!uns && raw[8*nbytes-1]) raw = raw | ~lmask;
        exp_ld = raw[31:0];

        bus_ack_in = 1'b0;
        req_valid_in = 1'b1; mem_wr_req_in = we; load_size_in = size;
        load_unsigned_in = uns; addr_in = addr; store_data_in = sdata;
        total++;
        if (req_ready_out !== 1'b1) begin bad++; $display("FAIL ready_before_accept: got %b required 1", req_ready_out); end
        step();
        // Scramble the request inputs: the unit must work from its registered copy.
        req_valid_in = exp_mis ? 1'b0 : 1'($urandom_range(0, 1));
        mem_wr_req_in = 1'($urandom); load_size_in = 2'($urandom);
        load_unsigned_in = 1'($urandom); addr_in = $urandom; store_data_in = $urandom;

        if (exp_mis) begin
            total++;
            if (bus_req_out !== 1'b0) begin bad++; $display("FAIL mis_no_bus_req: got %b required 0", bus_req_out); end
            total++;
            if ({misaligned_out, load_valid_out, store_done_out, bus_err_out} !== 4'b1000) begin
                bad++; $display("FAIL mis_pulse: got mis/lv/sd/be=%b required 1000", {misaligned_out, load_valid_out, store_done_out, bus_err_out});
            end
            total++;
            if (req_ready_out !== 1'b0) begin bad++; $display("FAIL mis_ready_low: got %b required 0", req_ready_out); end
        end else begin
            for (int k = 0; k < TO; k++) begin
                total++;
                if (bus_req_out !== 1'b1 || req_ready_out !== 1'b0) begin
                    bad++; $display("FAIL bus_phase cyc%0d: got req=%b ready=%b required req=1 ready=0", k, bus_req_out, req_ready_out);
                end
                total++;
                if (bus_addr_out !== (addr & ~32'h3) || bus_we_out !== we || bus_wmask_out !== exp_mask) begin
                    bad++; $display("FAIL bus_fields cyc%0d: got addr=%h we=%b mask=%b required addr=%h we=%b mask=%b",
                                    k, bus_addr_out, bus_we_out, bus_wmask_out, addr & ~32'h3, we, exp_mask);
                end
                if (we) begin
                    total++;
                    if (bus_wdata_out !== exp_wdata) begin bad++; $display("FAIL bus_wdata cyc%0d: got %h required %h", k, bus_wdata_out, exp_wdata); end
                end
                total++;
                if ({misaligned_out, load_valid_out, store_done_out, bus_err_out} !== 4'b0000) begin
                    bad++; $display("FAIL bus_no_pulse cyc%0d: got %b required 0000", k, {misaligned_out, load_valid_out, store_done_out, bus_err_out});
                end
                if (k == ack_delay) begin bus_ack_in = 1'b1; bus_rdata_in = rdata; end
                else begin bus_ack_in = 1'b0; bus_rdata_in = $urandom; end
                step();
                // Acks seen outside BUS must be ignored.
                bus_ack_in = 1'($urandom); bus_rdata_in = $urandom;
                if (k == ack_delay) break;
            end
            req_valid_in = 1'b0;
            ok = (ack_delay < TO);
            exp_lv = ok && !we;
            exp_sd = ok && we;
            exp_be = !ok;
            if (exp_lv) exp_load_data = exp_ld;
            total++;
            if (bus_req_out !== 1'b0) begin bad++; $display("FAIL done_bus_req: got %b required 0", bus_req_out); end
            total++;
            if ({misaligned_out, load_valid_out, store_done_out, bus_err_out} !== {1'b0, exp_lv, exp_sd, exp_be}) begin
                bad++; $display("FAIL done_pulse: got mis/lv/sd/be=%b required %b", {misaligned_out, load_valid_out, store_done_out, bus_err_out}, {1'b0, exp_lv, exp_sd, exp_be});
            end
            total++;
            if (load_data_out !== exp_load_data) begin bad++; $display("FAIL done_load_data: got %h required %h", load_data_out, exp_load_data); end
        end
        step();
        bus_ack_in = 1'b0;
        total++;
        if (req_ready_out !== 1'b1 || bus_req_out !== 1'b0) begin
            bad++; $display("FAIL after_ready: got ready=%b req=%b required ready=1 req=0", req_ready_out, bus_req_out);
        end
        total++;
        if ({misaligned_out, load_valid_out, store_done_out, bus_err_out} !== 4'b0000) begin
            bad++; $display("FAIL after_no_pulse: got %b required 0000", {misaligned_out, load_valid_out, store_done_out, bus_err_out});
        end
        total++;
        if (load_data_out !== exp_load_data) begin bad++; $display("FAIL after_load_hold: got %h required %h", load_data_out, exp_load_data); end
        $display("txn we=%b size=%0d uns=%b addr=%h ack_delay=%0d load_data=%h", we, size, uns, addr, ack_delay, load_data_out);
    endtask

    task automatic test_reset();
        reset_n_in = 1'b0; req_valid_in = 1'b0; mem_wr_req_in = 1'b0; load_size_in = 2'b00;
        load_unsigned_in = 1'b0; addr_in = '0; store_data_in = '0; bus_ack_in = 1'b0; bus_rdata_in = '0;
        #3;
        total++;
        if (req_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", req_ready_out); end
        total++;
        if ({bus_req_out, bus_we_out, bus_addr_out, bus_wdata_out, bus_wmask_out, load_data_out,
             load_valid_out, store_done_out, misaligned_out, bus_err_out} !== '0) begin
            bad++; $display("FAIL reset_outputs: got req=%b addr=%h ld=%h lv=%b sd=%b mis=%b be=%b required all 0",
                            bus_req_out, bus_addr_out, load_data_out, load_valid_out, store_done_out, misaligned_out, bus_err_out);
        end
        step(); step();
        reset_n_in = 1'b1;
        exp_load_data = 32'd0;
        step();
        $display("reset done ready=%b", req_ready_out);
    endtask

    task automatic test_byte_load();
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        total++;
        if (load_data_out !== 32'hFFFF_FF80) begin bad++; $display("FAIL byte_load_value: got %h required ffffff80", load_data_out); end
    endtask

    task automatic test_half_store();
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1);
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0);
        run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h1234_5678, 1000);
        run_txn(1'b1, 2'b00, 1'b0, 32'h0000_4001, 32'h5A, 32'h0, 1000);
    endtask

    task automatic test_half_load_wait();
        bus_ack_in = 1'b1; bus_rdata_in = 32'hDEAD_BEEF; req_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus_req_out !== 1'b0 || req_ready_out !== 1'b1 ||
                {misaligned_out, load_valid_out, store_done_out, bus_err_out} !== 4'b0000 ||
                load_data_out !== exp_load_data) begin
                bad++; $display("FAIL idle_spurious_ack: got req=%b ready=%b pulses=%b ld=%h required 0 1 0000 %h",
                                bus_req_out, req_ready_out, {misaligned_out, load_valid_out, store_done_out, bus_err_out}, load_data_out, exp_load_data);
            end
        end
        bus_ack_in = 1'b0;
        // Ack on the last allowed BUS cycle: ack beats the timeout.
        run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 32'hF00D_0000, 3);
        total++;
        if (load_data_out !== 32'h0000_F00D) begin bad++; $display("FAIL half_load_value: got %h required 0000f00d", load_data_out); end
    endtask

    task automatic test_reset_mid_bus();
        req_valid_in = 1'b1; mem_wr_req_in = 1'b0; load_size_in = 2'b10; load_unsigned_in = 1'b0;
        addr_in = 32'h0000_5000; bus_ack_in = 1'b0;
        step();
        req_valid_in = 1'b0;
        step();
        total++;
        if (bus_req_out !== 1'b1) begin bad++; $display("FAIL pre_reset_bus: got %b required 1", bus_req_out); end
        #2 reset_n_in = 1'b0;
        #1;
        exp_load_data = 32'd0;
        total++;
        if (bus_req_out !== 1'b0 || req_ready_out !== 1'b1) begin
            bad++; $display("FAIL async_reset_abort: got req=%b ready=%b required req=0 ready=1", bus_req_out, req_ready_out);
        end
        total++;
        if (load_data_out !== 32'd0) begin bad++; $display("FAIL async_reset_clear: got %h required 0", load_data_out); end
        step();
        reset_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({misaligned_out, load_valid_out, store_done_out, bus_err_out} !== 4'b0000 || bus_req_out !== 1'b0) begin
                bad++; $display("FAIL post_reset_quiet: got pulses=%b req=%b required 0000 0", {misaligned_out, load_valid_out, store_done_out, bus_err_out}, bus_req_out);
            end
        end
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0, 32'hCAFE_BABE, 2);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 60; i++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) a = a & ~32'h3;
            run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_6000, 32'h1111_2222, 32'h0, 0);
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_6001, 32'h0, 32'h0000_9900, 0);
        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_6002, 32'h0, 32'h8001_0000, 0);
    endtask

    initial begin
        test_reset();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_timeout();
        test_half_load_wait();
        test_reset_mid_bus();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
